// File: rtl/dag_log_sched.sv
// dag_log_sched: two-requester round-robin front end feeding one shared logic DAG
// (result = (a|b) & ((a|b)^b)), with a registered, back-pressurable response.
//
// Ports:
//   clock       - rising-edge clock for all state
//   reset_n     - asynchronous active-low reset
//   req_valid   - per-requester request valid (bit i = requester i)
//   req_a/req_b - operands, requester i in bits [i*BITS +: BITS]
//   req_ready   - one-hot accept strobe, high only in IDLE on a grant
//   resp_valid  - result held and valid (RESP state)
//   resp_ready  - consumer accepts result
//   resp_data   - DAG result for the granted requester
//   resp_id     - requester that owns resp_data
//   busy        - high in EXEC and RESP
//   op_count    - completed response handshakes, wraps
module dag_log_sched #(
    parameter int unsigned BITS  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    input  logic [2*BITS-1:0]   req_a,
    input  logic [2*BITS-1:0]   req_b,
    output logic [1:0]          req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [BITS-1:0]     resp_data,
    output logic                resp_id,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic              r_last;       // last granted requester
    logic [BITS-1:0]   r_a;
    logic [BITS-1:0]   r_b;
    logic              r_id;
    logic [BITS-1:0]   r_data;
    logic              r_resp_id;
    logic [CNT_W-1:0]  r_count;

    logic              w_grant_any;
    logic              w_grant_id;
    logic              w_grant;
    logic              w_hs;
    logic [BITS-1:0]   w_sel_a;
    logic [BITS-1:0]   w_sel_b;
    logic [BITS-1:0]   w_t1;
    logic [BITS-1:0]   w_t2;
    logic [BITS-1:0]   w_result;

    // Round-robin: on contention favour the requester not granted last;
    // a lone requester wins regardless of the pointer.
    always_comb begin
        w_grant_any = |req_valid;
        if (&req_valid) begin
            w_grant_id = ~r_last;
        end else begin
            w_grant_id = req_valid[1];
        end
    end

    assign w_sel_a = w_grant_id ? req_a[2*BITS-1:BITS] : req_a[BITS-1:0];
    assign w_sel_b = w_grant_id ? req_b[2*BITS-1:BITS] : req_b[BITS-1:0];

    // The single shared DAG evaluation, fed only from latched operands.
    assign w_t1     = r_a | r_b;
    assign w_t2     = w_t1 ^ r_b;
    assign w_result = w_t1 & w_t2;

    always_comb begin
        w_state_next = r_state;
        req_ready    = 2'b00;
        resp_valid   = 1'b0;
        busy         = 1'b0;
        w_grant      = 1'b0;
        w_hs         = 1'b0;
        unique case (r_state)
            StIdle: begin
                // reset_n gating keeps req_ready low while reset is held.
                if (w_grant_any && reset_n) begin
                    w_grant      = 1'b1;
                    req_ready    = w_grant_id ? 2'b10 : 2'b01;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                busy         = 1'b1;
                w_state_next = StResp;
            end
            StResp: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_hs         = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_last    <= 1'b1;
            r_a       <= '0;
            r_b       <= '0;
            r_id      <= 1'b0;
            r_data    <= '0;
            r_resp_id <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_id   <= w_grant_id;
                r_last <= w_grant_id;
            end
            if (r_state == StExec) begin
                r_data    <= w_result;
                r_resp_id <= r_id;
            end
            if (w_hs) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign resp_data = r_data;
    assign resp_id   = r_resp_id;
    assign op_count  = r_count;

endmodule
